move_controller: RTL and testbench
==================================

MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, SELECT-state cycles before turn forfeit (used only with MOVE_TIMEOUT_EN).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  level; rising edge begins a game from IDLE or OVER.
REQ-005 btn_up, btn_down, btn_left, btn_right  in  1 each  debounced, clk-synchronous levels; cursor moves.
REQ-006 btn_confirm  in  1  debounced, clk-synchronous level; commit move at cursor.
REQ-007 grid_in  in  18  current board from marker/recorder stage; cell i at bits [2i+1:2i]; 00 empty, 01 O, 10 X.
REQ-008 game_over  in  1  level from win checker; ends play.
REQ-009 mark  out  2  move strobe to marker/recorder: 10 X, 01 O, 00 none.
REQ-010 position  out  4  cell index 0-8 accompanying mark.
REQ-011 whosTurn  out  1  1 X to move, 0 O to move.
REQ-012 game_state  out  1  1 while a game is in play.
REQ-013 cursor  out  4  highlighted cell, index = row*3+col.
REQ-014 reject  out  1  one-cycle pulse: confirm on occupied cell.
REQ-015 timeout  out  1  one-cycle pulse: turn forfeited.
REQ-016 move_count  out  8  accepted moves this game.

Function
REQ-017 Inputs start and btn_* are rising-edge detected against a registered previous value; held levels act once.
REQ-018 FSM states IDLE, SELECT, COMMIT, SETTLE, OVER; all outputs registered.
REQ-019 IDLE/OVER + start edge -> SELECT; whosTurn=1, cursor=4, move_count=0, timer=0.
REQ-020 SELECT + game_over=1 -> OVER, takes priority over every button in that cycle.
REQ-021 SELECT direction edge: up row-1, down row+1, left col-1, right col+1, each wrapping mod 3 within its axis.
REQ-022 Simultaneous direction edges: only highest priority acts, up > down > left > right.
REQ-023 Confirm edge with any direction edge same cycle: confirm acts, directions ignored.
REQ-024 SELECT confirm edge, grid_in[cursor]==00 -> COMMIT; position<=cursor; mark<=whosTurn?10:01.
REQ-025 SELECT confirm edge, grid_in[cursor]!=00 -> reject=1 one cycle, stay SELECT, no state change otherwise.
REQ-026 mark is nonzero exactly one cycle (COMMIT); 00 in all other states.
REQ-027 COMMIT -> SETTLE unconditionally; SETTLE -> SELECT, toggling whosTurn and incrementing move_count (saturate at 255).
REQ-028 Latency: confirm edge sampled at edge k -> mark valid after k, whosTurn toggled after k+2, next confirm accepted from edge k+3.
REQ-029 Buttons and start ignored in COMMIT and SETTLE; game_over in COMMIT/SETTLE is acted on only after return to SELECT.
REQ-030 position holds last committed cell until next commit.
REQ-031 game_state=1 in SELECT, COMMIT, SETTLE; 0 in IDLE, OVER.

Reset
REQ-032 rst low, any state/cycle: state=IDLE, mark=00, position=0, whosTurn=1, game_state=0, cursor=4, reject=0, timeout=0, move_count=0, timer=0, edge-detect registers=0.
REQ-033 rst mid-COMMIT: mark drops to 00 asynchronously; no move is issued after release.
REQ-034 First clk after rst release: a level already high on start or btn_* is not treated as an edge.

Configuration
REQ-035 Macro MOVE_TIMEOUT_EN defined: counter counts cycles in SELECT, cleared on entry to SELECT and on any accepted move.
REQ-036 With MOVE_TIMEOUT_EN, counter reaching TIMEOUT_CYCLES-1 in SELECT with no confirm edge: timeout=1 one cycle, whosTurn toggles, counter clears, no mark, move_count unchanged.
REQ-037 Confirm edge in the same cycle as expiry: confirm wins, no timeout.
REQ-038 MOVE_TIMEOUT_EN undefined: no counter logic; timeout tied 0; TIMEOUT_CYCLES unused.

Verification
REQ-039 rst low then start edge -> game_state=1, whosTurn=1, cursor=4, mark=00.
REQ-040 Empty grid, cursor 4, confirm -> one cycle mark=10 position=4; two cycles later whosTurn=0, move_count=1.
REQ-041 Cursor 0, left edge -> cursor 2; up edge -> cursor 8; up+right same cycle -> cursor 5 (up only).
REQ-042 grid_in cell 4 = 01, confirm at cursor 4 -> reject=1 one cycle, mark stays 00, whosTurn unchanged.
REQ-043 game_over=1 with confirm in SELECT -> OVER, game_state=0, no mark; start edge -> SELECT, move_count=0.
REQ-044 MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=8, idle in SELECT 8 cycles -> timeout=1, whosTurn 1->0, mark 00.

Source files
------------

// File: rtl/move_controller.sv
// Tic-tac-toe move controller: cursor navigation, move commit strobe, turn tracking.
// Optional per-turn forfeit timer enabled by defining MOVE_TIMEOUT_EN.
module move_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_confirm,
   input  logic [17:0] grid_in,
   input  logic        game_over,
   output logic [1:0]  mark,
   output logic [3:0]  position,
   output logic        whosTurn,
   output logic        game_state,
   output logic [3:0]  cursor,
   output logic        reject,
   output logic        timeout,
   output logic [7:0]  move_count
);

   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_COMMIT, S_SETTLE, S_OVER} state_t;

   state_t      state_q, state_d;
   logic        arm_q;
   logic        start_q, up_q, down_q, left_q, right_q, conf_q;
   logic [1:0]  mark_q, mark_d;
   logic [3:0]  pos_q, pos_d;
   logic        whos_q, whos_d;
   logic        gs_q, gs_d;
   logic [3:0]  cursor_q, cursor_d;
   logic        reject_q, reject_d;
   logic        timeout_q, timeout_d;
   logic [7:0]  count_q, count_d;
`ifdef MOVE_TIMEOUT_EN
   logic [31:0] timer_q, timer_d;
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   // Edges are masked on the first clock after reset so held levels do not fire.
   logic start_e, up_e, down_e, left_e, right_e, conf_e;
   assign start_e = arm_q & start       & ~start_q;
   assign up_e    = arm_q & btn_up      & ~up_q;
   assign down_e  = arm_q & btn_down    & ~down_q;
   assign left_e  = arm_q & btn_left    & ~left_q;
   assign right_e = arm_q & btn_right   & ~right_q;
   assign conf_e  = arm_q & btn_confirm & ~conf_q;

   function automatic logic [1:0] cell_at(input logic [17:0] g, input logic [3:0] idx);
      logic [17:0] sh;
      sh = g >> {idx, 1'b0};
      return sh[1:0];
   endfunction

   function automatic logic [3:0] move_up(input logic [3:0] c);
      return (c >= 4'd3) ? c - 4'd3 : c + 4'd6;
   endfunction

   function automatic logic [3:0] move_down(input logic [3:0] c);
      return (c <= 4'd5) ? c + 4'd3 : c - 4'd6;
   endfunction

   function automatic logic [3:0] move_left(input logic [3:0] c);
      return (c == 4'd0 || c == 4'd3 || c == 4'd6) ? c + 4'd2 : c - 4'd1;
   endfunction

   function automatic logic [3:0] move_right(input logic [3:0] c);
      return (c == 4'd2 || c == 4'd5 || c == 4'd8) ? c - 4'd2 : c + 4'd1;
   endfunction

   always_comb begin
      state_d   = state_q;
      mark_d    = 2'b00;
      pos_d     = pos_q;
      whos_d    = whos_q;
      cursor_d  = cursor_q;
      reject_d  = 1'b0;
      timeout_d = 1'b0;
      count_d   = count_q;
`ifdef MOVE_TIMEOUT_EN
      timer_d   = timer_q;
`endif
      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_e) begin
               state_d  = S_SELECT;
               whos_d   = 1'b1;
               cursor_d = 4'd4;
               count_d  = 8'd0;
`ifdef MOVE_TIMEOUT_EN
               timer_d  = 32'd0;
`endif
            end
         end
         S_SELECT: begin
`ifdef MOVE_TIMEOUT_EN
            timer_d = timer_q + 32'd1;
`endif
            if (game_over) begin
               state_d = S_OVER;
            end else if (conf_e) begin
               if (cell_at(grid_in, cursor_q) == 2'b00) begin
                  state_d = S_COMMIT;
                  pos_d   = cursor_q;
                  mark_d  = whos_q ? 2'b10 : 2'b01;
`ifdef MOVE_TIMEOUT_EN
                  timer_d = 32'd0;
`endif
               end else begin
                  reject_d = 1'b1;
               end
            end else begin
               if (up_e)         cursor_d = move_up(cursor_q);
               else if (down_e)  cursor_d = move_down(cursor_q);
               else if (left_e)  cursor_d = move_left(cursor_q);
               else if (right_e) cursor_d = move_right(cursor_q);
`ifdef MOVE_TIMEOUT_EN
               if (timer_q >= 32'(TIMEOUT_CYCLES - 1)) begin
                  timeout_d = 1'b1;
                  whos_d    = ~whos_q;
                  timer_d   = 32'd0;
               end
`endif
            end
         end
         S_COMMIT: state_d = S_SETTLE;
         S_SETTLE: begin
            state_d = S_SELECT;
            whos_d  = ~whos_q;
            count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
`ifdef MOVE_TIMEOUT_EN
            timer_d = 32'd0;
`endif
         end
         default: state_d = S_IDLE;
      endcase
      gs_d = (state_d == S_SELECT) || (state_d == S_COMMIT) || (state_d == S_SETTLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         arm_q     <= 1'b0;
         start_q   <= 1'b0;
         up_q      <= 1'b0;
         down_q    <= 1'b0;
         left_q    <= 1'b0;
         right_q   <= 1'b0;
         conf_q    <= 1'b0;
         mark_q    <= 2'b00;
         pos_q     <= 4'd0;
         whos_q    <= 1'b1;
         gs_q      <= 1'b0;
         cursor_q  <= 4'd4;
         reject_q  <= 1'b0;
         timeout_q <= 1'b0;
         count_q   <= 8'd0;
`ifdef MOVE_TIMEOUT_EN
         timer_q   <= 32'd0;
`endif
      end else begin
         state_q   <= state_d;
         arm_q     <= 1'b1;
         start_q   <= start;
         up_q      <= btn_up;
         down_q    <= btn_down;
         left_q    <= btn_left;
         right_q   <= btn_right;
         conf_q    <= btn_confirm;
         mark_q    <= mark_d;
         pos_q     <= pos_d;
         whos_q    <= whos_d;
         gs_q      <= gs_d;
         cursor_q  <= cursor_d;
         reject_q  <= reject_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
`ifdef MOVE_TIMEOUT_EN
         timer_q   <= timer_d;
`endif
      end
   end

   assign mark       = mark_q;
   assign position   = pos_q;
   assign whosTurn   = whos_q;
   assign game_state = gs_q;
   assign cursor     = cursor_q;
   assign reject     = reject_q;
   assign timeout    = timeout_q;
   assign move_count = count_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller; a second instance with an 8-cycle forfeit timer
// covers the MOVE_TIMEOUT_EN behaviour (or its absence in the default build).
module tb_move_controller;

   logic        clk, rst, start, start_t;
   logic        btn_up, btn_down, btn_left, btn_right, btn_confirm, game_over;
   logic [17:0] grid_in;
   logic [1:0]  mark, mark_t;
   logic [3:0]  position, position_t, cursor, cursor_t;
   logic        whosTurn, whosTurn_t, game_state, game_state_t;
   logic        reject, reject_t, timeout, timeout_t;
   logic [7:0]  move_count, move_count_t;

   int n_tests = 0;
   int n_fail  = 0;

   move_controller u_dut (
      .clk(clk), .rst(rst), .start(start),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .btn_confirm(btn_confirm), .grid_in(grid_in), .game_over(game_over),
      .mark(mark), .position(position), .whosTurn(whosTurn), .game_state(game_state),
      .cursor(cursor), .reject(reject), .timeout(timeout), .move_count(move_count)
   );

   move_controller #(.TIMEOUT_CYCLES(8)) u_to (
      .clk(clk), .rst(rst), .start(start_t),
      .btn_up(1'b0), .btn_down(1'b0), .btn_left(1'b0), .btn_right(1'b0),
      .btn_confirm(1'b0), .grid_in(18'd0), .game_over(1'b0),
      .mark(mark_t), .position(position_t), .whosTurn(whosTurn_t), .game_state(game_state_t),
      .cursor(cursor_t), .reject(reject_t), .timeout(timeout_t), .move_count(move_count_t)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic u, input logic d, input logic l, input logic r);
      btn_up = u; btn_down = d; btn_left = l; btn_right = r;
      step();
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b0; start = 1'b1; start_t = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      btn_confirm = 1'b0; game_over = 1'b0; grid_in = 18'd0;

      // reset values
      repeat (3) step();
      check("rst_state",   {31'd0, game_state}, 32'd0);
      check("rst_mark",    {30'd0, mark}, 32'd0);
      check("rst_pos",     {28'd0, position}, 32'd0);
      check("rst_turn",    {31'd0, whosTurn}, 32'd1);
      check("rst_cursor",  {28'd0, cursor}, 32'd4);
      check("rst_reject",  {31'd0, reject}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_count",   {24'd0, move_count}, 32'd0);

      // start held through release is not an edge
      #2 rst = 1'b1;
      step();
      check("start_held", {31'd0, game_state}, 32'd0);
      start = 1'b0; step();
      start = 1'b1; step();
      check("start_state",  {31'd0, game_state}, 32'd1);
      check("start_turn",   {31'd0, whosTurn}, 32'd1);
      check("start_cursor", {28'd0, cursor}, 32'd4);
      check("start_mark",   {30'd0, mark}, 32'd0);
      start = 1'b0; step();

      // first move: X at centre
      btn_confirm = 1'b1; step();
      check("mv1_mark", {30'd0, mark}, 32'd2);
      check("mv1_pos",  {28'd0, position}, 32'd4);
      btn_confirm = 1'b0; step();
      check("mv1_mark_off", {30'd0, mark}, 32'd0);
      check("mv1_turn_k1",  {31'd0, whosTurn}, 32'd1);
      step();
      check("mv1_turn_k2", {31'd0, whosTurn}, 32'd0);
      check("mv1_count",   {24'd0, move_count}, 32'd1);

      // cursor navigation with wrap and priority
      press(1'b1, 1'b0, 1'b0, 1'b0);
      check("nav_up_4", {28'd0, cursor}, 32'd1);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      check("nav_left_1", {28'd0, cursor}, 32'd0);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      check("nav_left_wrap", {28'd0, cursor}, 32'd2);
      press(1'b1, 1'b0, 1'b0, 1'b0);
      check("nav_up_wrap", {28'd0, cursor}, 32'd8);
      press(1'b1, 1'b0, 1'b0, 1'b1);
      check("nav_up_right", {28'd0, cursor}, 32'd5);

      // confirm wins over a direction in the same cycle; O moves at 5
      btn_confirm = 1'b1; btn_down = 1'b1; step();
      check("mv2_mark",   {30'd0, mark}, 32'd1);
      check("mv2_pos",    {28'd0, position}, 32'd5);
      check("mv2_cursor", {28'd0, cursor}, 32'd5);
      btn_confirm = 1'b0; btn_down = 1'b0; step(); step();
      check("mv2_turn",  {31'd0, whosTurn}, 32'd1);
      check("mv2_count", {24'd0, move_count}, 32'd2);

      // occupied cell is rejected
      press(1'b0, 1'b0, 1'b1, 1'b0);
      check("nav_left_5", {28'd0, cursor}, 32'd4);
      grid_in = 18'h00100;
      btn_confirm = 1'b1; step();
      check("rej_pulse", {31'd0, reject}, 32'd1);
      check("rej_mark",  {30'd0, mark}, 32'd0);
      btn_confirm = 1'b0; step();
      check("rej_off",   {31'd0, reject}, 32'd0);
      check("rej_turn",  {31'd0, whosTurn}, 32'd1);
      check("rej_count", {24'd0, move_count}, 32'd2);
      check("rej_pos",   {28'd0, position}, 32'd5);
      check("rej_state", {31'd0, game_state}, 32'd1);

      // buttons ignored during COMMIT/SETTLE
      grid_in = 18'd0;
      btn_confirm = 1'b1; step();
      check("mv3_mark", {30'd0, mark}, 32'd2);
      btn_confirm = 1'b0; btn_right = 1'b1; step();
      btn_right = 1'b0; step();
      check("mv3_cursor", {28'd0, cursor}, 32'd4);
      check("mv3_turn",   {31'd0, whosTurn}, 32'd0);
      check("mv3_count",  {24'd0, move_count}, 32'd3);

      // game_over beats confirm; restart clears count
      game_over = 1'b1; btn_confirm = 1'b1; step();
      check("over_state", {31'd0, game_state}, 32'd0);
      check("over_mark",  {30'd0, mark}, 32'd0);
      check("over_count", {24'd0, move_count}, 32'd3);
      game_over = 1'b0; btn_confirm = 1'b0; step();
      start = 1'b1; step();
      check("restart_state",  {31'd0, game_state}, 32'd1);
      check("restart_count",  {24'd0, move_count}, 32'd0);
      check("restart_turn",   {31'd0, whosTurn}, 32'd1);
      check("restart_cursor", {28'd0, cursor}, 32'd4);
      start = 1'b0; step();

      // reset in the middle of COMMIT
      btn_confirm = 1'b1; step();
      check("mid_mark", {30'd0, mark}, 32'd2);
      #2 rst = 1'b0;
      #1;
      check("mid_mark_async", {30'd0, mark}, 32'd0);
      btn_confirm = 1'b0;
      #3 rst = 1'b1;
      step(); step();
      check("post_rst_mark",  {30'd0, mark}, 32'd0);
      check("post_rst_state", {31'd0, game_state}, 32'd0);
      check("post_rst_pos",   {28'd0, position}, 32'd0);

      // forfeit timer on the 8-cycle instance
      start_t = 1'b1; step();
      start_t = 1'b0;
      check("to_state", {31'd0, game_state_t}, 32'd1);
      repeat (7) step();
      check("to_early", {31'd0, timeout_t}, 32'd0);
      check("to_early_turn", {31'd0, whosTurn_t}, 32'd1);
      step();
`ifdef MOVE_TIMEOUT_EN
      check("to_pulse", {31'd0, timeout_t}, 32'd1);
      check("to_turn",  {31'd0, whosTurn_t}, 32'd0);
`else
      check("to_pulse", {31'd0, timeout_t}, 32'd0);
      check("to_turn",  {31'd0, whosTurn_t}, 32'd1);
`endif
      check("to_mark",  {30'd0, mark_t}, 32'd0);
      check("to_count", {24'd0, move_count_t}, 32'd0);
      step();
      check("to_pulse_off", {31'd0, timeout_t}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
